// File: rtl/color_scan_ctrl.sv
// Frame-sequenced RGB565 ROI classifier: counts red/green/blue pixels over one frame and votes a colour.
// Define COLOR_SCAN_CONT_EN for continuous mode (a result every frame, start ignored).
module color_scan_ctrl #(
   parameter int ROI_X0  = 40,
   parameter int ROI_X1  = 119,
   parameter int ROI_Y0  = 30,
   parameter int ROI_Y1  = 89,
   parameter int MIN_PIX = 64,
   parameter int CNT_W   = 13
) (
   input  logic        p_clock,
   input  logic        rst,
   input  logic        start,
   input  logic        vsync,
   input  logic        href,
   input  logic        pix_valid,
   input  logic [15:0] pixel_data,
   output logic        busy,
   output logic        done,
   output logic [2:0]  color,
   output logic [2:0]  led
);
   typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACCUM, DECIDE} state_t;

   localparam logic [1:0]       CLS_NONE = 2'd0;
   localparam logic [1:0]       CLS_R    = 2'd1;
   localparam logic [1:0]       CLS_G    = 2'd2;
   localparam logic [1:0]       CLS_B    = 2'd3;
   localparam logic [9:0]       X0       = 10'(ROI_X0);
   localparam logic [9:0]       X1       = 10'(ROI_X1);
   localparam logic [9:0]       Y0       = 10'(ROI_Y0);
   localparam logic [9:0]       Y1       = 10'(ROI_Y1);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIX);

   function automatic logic [1:0] classify(input logic [15:0] px);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = px[15:11];
      g = px[10:5];
      b = px[4:0];
      if (r > 5'd17 && g < 6'd20 && b < 5'd11)      classify = CLS_R;
      else if (r < 5'd11 && g > 6'd28 && b < 5'd11) classify = CLS_G;
      else if (r < 5'd11 && g < 6'd20 && b > 5'd17) classify = CLS_B;
      else                                          classify = CLS_NONE;
   endfunction

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
      sat_cnt = (c == '1) ? c : c + 1'b1;
   endfunction

   function automatic logic [9:0] sat_pos(input logic [9:0] p);
      sat_pos = (p == 10'd1023) ? p : p + 10'd1;
   endfunction

   function automatic logic [2:0] vote(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                       input logic [CNT_W-1:0] b);
      if (r > g && r > b && r >= MIN_CNT)      vote = 3'b100;
      else if (g > r && g > b && g >= MIN_CNT) vote = 3'b010;
      else if (b > r && b > g && b >= MIN_CNT) vote = 3'b001;
      else                                     vote = 3'b111;
   endfunction

   state_t           state, state_nxt;
   logic             vs_p0, vs_p1, hr_p0, hr_p1, pv_p0;
   logic [15:0]      px_p0;
   logic [9:0]       col, row, pix_col;
   logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
   logic             vs_edge, hr_rise, hr_fall, pix_take, in_roi, count_en, clr_cnt;
   logic [1:0]       pix_cls;
   logic [2:0]       result;

`ifdef COLOR_SCAN_CONT_EN
   logic unused_start;
   assign unused_start = start;
`endif

   // Stage p0: input capture; p1 holds the previous sync levels for edge detection
   always_ff @(posedge p_clock) begin
      px_p0 <= pixel_data;
      if (rst) begin
         vs_p0 <= 1'b0;
         vs_p1 <= 1'b0;
         hr_p0 <= 1'b0;
         hr_p1 <= 1'b0;
         pv_p0 <= 1'b0;
      end else begin
         vs_p0 <= vsync;
         vs_p1 <= vs_p0;
         hr_p0 <= href;
         hr_p1 <= hr_p0;
         pv_p0 <= pix_valid;
      end
   end

   assign vs_edge  = vs_p0 & ~vs_p1;
   assign hr_rise  = hr_p0 & ~hr_p1;
   assign hr_fall  = ~hr_p0 & hr_p1;
   assign pix_take = hr_p0 & pv_p0;
   assign pix_col  = hr_rise ? '0 : col;
   assign in_roi   = (pix_col >= X0) && (pix_col <= X1) && (row >= Y0) && (row <= Y1);
   assign pix_cls  = classify(px_p0);
   // The ending vsync edge cycle is excluded so a pixel sampled with it never counts
   assign count_en = (state == ACCUM) && !vs_edge && pix_take && in_roi;
   assign clr_cnt  = (state_nxt == ACCUM) && (state != ACCUM);
   assign result   = vote(cnt_r, cnt_g, cnt_b);
   assign busy     = (state != IDLE);

   always_ff @(posedge p_clock) begin
      if (rst || vs_edge) begin
         col <= '0;
         row <= '0;
      end else begin
         if (hr_rise)       col <= pv_p0 ? 10'd1 : 10'd0;
         else if (pix_take) col <= sat_pos(col);
         if (hr_fall)       row <= sat_pos(row);
      end
   end

   // Stage p1: class counters updated one edge after the pixel was sampled
   always_ff @(posedge p_clock) begin
      if (rst || clr_cnt) begin
         cnt_r <= '0;
         cnt_g <= '0;
         cnt_b <= '0;
      end else if (count_en) begin
         case (pix_cls)
            CLS_R:   cnt_r <= sat_cnt(cnt_r);
            CLS_G:   cnt_g <= sat_cnt(cnt_g);
            CLS_B:   cnt_b <= sat_cnt(cnt_b);
            default: ;
         endcase
      end
   end

   always_ff @(posedge p_clock) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
`ifdef COLOR_SCAN_CONT_EN
         IDLE:       state_nxt = WAIT_FRAME;
`else
         IDLE:       if (start) state_nxt = WAIT_FRAME;
`endif
         WAIT_FRAME: if (vs_edge) state_nxt = ACCUM;
         ACCUM:      if (vs_edge) state_nxt = DECIDE;
`ifdef COLOR_SCAN_CONT_EN
         DECIDE:     state_nxt = ACCUM;
`else
         DECIDE:     state_nxt = IDLE;
`endif
         default:    state_nxt = IDLE;
      endcase
   end

   // Stage p2: result registers, loaded as DECIDE completes
   always_ff @(posedge p_clock) begin
      if (rst) begin
         done  <= 1'b0;
         color <= 3'b000;
         led   <= 3'b000;
      end else begin
         done <= (state == DECIDE);
         if (state == DECIDE) begin
            color <= result;
            led   <= result;
         end
      end
   end
endmodule

// File: tb/tb_color_scan_ctrl.sv
// Self-checking bench for color_scan_ctrl (single-shot build): frame-level model scored every cycle.
`timescale 1ns/1ps
module tb_color_scan_ctrl;
   localparam int FW = 121;
   localparam int FH = 91;
   localparam logic [15:0] RED = 16'hF800;
   localparam logic [15:0] GRN = 16'h07E0;
   localparam logic [15:0] BLU = 16'h001F;

   logic        p_clock = 1'b0, rst = 1'b1, start = 1'b0, vsync = 1'b0, href = 1'b0, pix_valid = 1'b0;
   logic [15:0] pixel_data = 16'h0;
   logic        busy, done;
   logic [2:0]  color, led;

   color_scan_ctrl dut (
      .p_clock(p_clock), .rst(rst), .start(start), .vsync(vsync), .href(href),
      .pix_valid(pix_valid), .pixel_data(pixel_data),
      .busy(busy), .done(done), .color(color), .led(led)
   );

   always #5 p_clock = ~p_clock;

   int cyc = 0;
   always @(posedge p_clock) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   int busy_lo = 1 << 30, busy_hi = -1, done_at = -1, col_from = 0;
   logic [2:0] col_old = 3'b000, col_new = 3'b000;
   int cnt [3];
   bit meas = 0, armed = 0, chk = 0;
   int fav = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge p_clock) begin
      logic [2:0] ec;
      if (chk) begin
         ec = (cyc >= col_from) ? col_new : col_old;
         check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
         check("done", 32'(done), 32'(cyc == done_at));
         check("color", 32'(color), 32'(ec));
         check("led", 32'(led), 32'(ec));
      end
   end

   function automatic int classify(input logic [15:0] px);
      int r, g, b;
      r = int'(px[15:11]);
      g = int'(px[10:5]);
      b = int'(px[4:0]);
      if (r > 17 && g < 20 && b < 11) return 0;
      if (r < 11 && g > 28 && b < 11) return 1;
      if (r < 11 && g < 20 && b > 17) return 2;
      return 3;
   endfunction

   function automatic bit inroi(input int row, input int col);
      return col >= 40 && col <= 119 && row >= 30 && row <= 89;
   endfunction

   function automatic logic [2:0] vote_of();
      int mx, nmx, idx;
      logic [2:0] one;
      mx = 0; nmx = 0; idx = 0; one = 3'b100;
      for (int i = 0; i < 3; i++) if (cnt[i] > mx) begin mx = cnt[i]; idx = i; end
      for (int i = 0; i < 3; i++) if (cnt[i] == mx) nmx++;
      if (nmx != 1 || mx < 64) return 3'b111;
      return one >> idx;
   endfunction

   function automatic logic [15:0] mk(input int c);
      logic [4:0] r, b;
      logic [5:0] g;
      case (c)
         0: begin r = 5'($urandom_range(31, 18)); g = 6'($urandom_range(19, 0)); b = 5'($urandom_range(10, 0)); end
         1: begin r = 5'($urandom_range(10, 0)); g = 6'($urandom_range(63, 29)); b = 5'($urandom_range(10, 0)); end
         default: begin r = 5'($urandom_range(10, 0)); g = 6'($urandom_range(19, 0)); b = 5'($urandom_range(31, 18)); end
      endcase
      return {r, g, b};
   endfunction

   function automatic logic [15:0] pat(input int p, input int row, input int col);
      int k;
      case (p)
         0: return RED;
         1: return inroi(row, col) ? GRN : BLU;
         2: return !inroi(row, col) ? 16'h0 : (row < 60 ? RED : BLU);
         3: return (row == 30 && col >= 40 && col < 90) ? GRN : 16'h0;
         4: begin
            k = int'($urandom_range(9, 0));
            if (k < 3) return 16'($urandom);
            if (k < 6) return mk(fav);
            return mk(int'($urandom_range(2, 0)));
         end
         default: begin
            if (row < 30) return 16'($urandom);
            if (row == 30 && col >= 40) return RED;
            if (row == 31 && col >= 40 && col <= 118) return BLU;
            if (row == 60 && col == 49) return BLU;
            return 16'h0;
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge p_clock);
      #1;
   endtask

   task automatic drive_line(input int p, input int row, input int npix, input bit gaps, input bit keep);
      int col, c;
      col = 0;
      while (col < npix) begin
         href = 1'b1;
         if (gaps && $urandom_range(7, 0) == 0) begin
            pix_valid = 1'b0;
            pixel_data = 16'($urandom);
         end else begin
            pix_valid = 1'b1;
            pixel_data = pat(p, row, col);
            if (meas && inroi(row, col)) begin
               c = classify(pixel_data);
               if (c < 3) cnt[c]++;
            end
            col++;
         end
         tick();
      end
      pix_valid = 1'b0;
      if (!keep) begin
         href = 1'b0;
         tick();
         tick();
      end
   endtask

   // Rising vsync: starts an armed measurement or closes the running one.
   task automatic vsync_pulse(input bit edge_pix);
      vsync = 1'b1;
      if (edge_pix) begin
         href = 1'b1;
         pix_valid = 1'b1;
         pixel_data = RED;
      end
      if (meas) begin
         meas = 0;
         col_old = (cyc >= col_from) ? col_new : col_old;
         col_new = vote_of();
         col_from = cyc + 3;
         done_at = cyc + 3;
         busy_hi = cyc + 2;
      end else if (armed) begin
         armed = 0;
         meas = 1;
         cnt = '{0, 0, 0};
      end
      tick();
      pix_valid = 1'b0;
      href = 1'b0;
      repeat (2) tick();
      vsync = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      if (!(cyc >= busy_lo && cyc <= busy_hi)) begin
         busy_lo = cyc + 1;
         busy_hi = 1 << 30;
         armed = 1;
      end
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      busy_hi = cyc;
      col_old = (cyc >= col_from) ? col_new : col_old;
      col_new = 3'b000;
      col_from = cyc + 1;
      if (done_at > cyc) done_at = -1;
      meas = 0;
      armed = 0;
      tick();
      rst = 1'b0;
   endtask

   task automatic measure(input int p, input int w, input int h, input bit gaps);
      pulse_start();
      repeat (3) tick();
      vsync_pulse(0);
      for (int r = 0; r < h; r++) drive_line(p, r, w, gaps, 0);
      vsync_pulse(0);
      repeat (4) tick();
   endtask

   initial begin
      repeat (3) tick();
      chk = 1;
      rst = 1'b0;
      repeat (2) tick();

      // vsync while idle must not start anything
      vsync_pulse(0);
      repeat (3) tick();

      measure(0, 160, 120, 0);
      check("red model count", 32'(cnt[0]), 32'd4800);
      check("red color", 32'(color), 32'b100);
      check("red led", 32'(led), 32'b100);

      // reset in the middle of an accumulation
      pulse_start();
      repeat (3) tick();
      vsync_pulse(0);
      for (int r = 0; r < 40; r++) drive_line(0, r, FW, 0, 0);
      pulse_rst();
      repeat (2) tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset color", 32'(color), 32'd0);

      measure(1, FW, FH, 0);
      check("roi model green", 32'(cnt[1]), 32'd4800);
      check("roi model blue", 32'(cnt[2]), 32'd0);
      check("roi color", 32'(color), 32'b010);

      measure(2, FW, FH, 0);
      check("tie model red", 32'(cnt[0]), 32'd2400);
      check("tie model blue", 32'(cnt[2]), 32'd2400);
      check("tie color", 32'(color), 32'b111);

      measure(3, FW, 32, 0);
      check("thresh model green", 32'(cnt[1]), 32'd50);
      check("thresh color", 32'(color), 32'b111);

      fav = int'($urandom_range(2, 0));
      measure(4, FW, FH, 1);

      // extra starts while waiting and accumulating; a pixel rides on the vsync edge
      pulse_start();
      pulse_start();
      repeat (2) tick();
      vsync_pulse(0);
      for (int r = 0; r < 30; r++) drive_line(5, r, FW, 1, 0);
      pulse_start();
      for (int r = 30; r < 60; r++) drive_line(5, r, FW, 1, 0);
      drive_line(5, 60, 50, 1, 1);
      vsync_pulse(1);
      repeat (4) tick();
      check("edge model red", 32'(cnt[0]), 32'd80);
      check("edge model blue", 32'(cnt[2]), 32'd80);
      check("edge color", 32'(color), 32'b111);

      repeat (5) tick();
      chk = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
